// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N producers, the mux and its single consumer.
// master = producer/consumer side, slave = the mux itself.
interface rr_stream_mux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with a registered output stage.
// Channels are picked by explicit select or by round-robin arbitration.
module rr_stream_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    rr_stream_mux_if.slave  bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             space;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    assign space = !out_valid_q || bus.out_ready;

    always_comb begin : grant
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        if (mode) begin
            // Search starts just after the last granted channel, wrapping modulo N.
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (32'(rr_ptr_q) + k) % N;
                if (!gnt_valid && bus.in_valid[SELW'(idx)]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SELW'(idx);
                end
            end
        end else begin
            // Out-of-range sel matches no channel and therefore never grants.
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SELW'(i) && bus.in_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = sel;
                end
            end
        end
    end

    always_comb begin : data_mux
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : ready
        bus.in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bus.in_ready[i] = !rst && gnt_valid && space && (gnt_idx == SELW'(i));
        end
    end

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_valid && space) begin
            out_data_d  = gnt_data;
            out_src_d   = gnt_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_ptr_q    <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel instance and a 3-channel
// instance sharing clock and reset.
module tb_rr_stream_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_a = 1'b0;
    logic [1:0] sel_a = '0;
    logic mode_b = 1'b0;
    logic [1:0] sel_b = '0;

    int n_cmp = 0;
    int n_err = 0;

    rr_stream_mux_if #(.WIDTH(8), .N(4)) bus_a ();
    rr_stream_mux_if #(.WIDTH(8), .N(3)) bus_b ();

    rr_stream_mux #(.WIDTH(8), .N(4)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .mode (mode_a),
        .sel  (sel_a),
        .bus  (bus_a)
    );

    rr_stream_mux #(.WIDTH(8), .N(3)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .mode (mode_b),
        .sel  (sel_b),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out_a(input string tag, input logic [7:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(bus_a.out_valid), 32'd1);
        check({tag, ".data"}, 32'(bus_a.out_data), 32'(d));
        check({tag, ".src"}, 32'(bus_a.out_src), 32'(s));
    endtask

    task automatic out_b(input string tag, input logic [7:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(bus_b.out_valid), 32'd1);
        check({tag, ".data"}, 32'(bus_b.out_data), 32'(d));
        check({tag, ".src"}, 32'(bus_b.out_src), 32'(s));
    endtask

    initial begin
        bus_a.in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
        bus_a.in_valid  = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_data   = {8'h30, 8'h20, 8'h10};
        bus_b.in_valid  = '0;
        bus_b.out_ready = 1'b0;

        // Reset then idle
        step();
        step();
        check("rst.valid", 32'(bus_a.out_valid), 32'd0);
        check("rst.data", 32'(bus_a.out_data), 32'h00);
        check("rst.src", 32'(bus_a.out_src), 32'd0);
        check("rst.ready", 32'(bus_a.in_ready), 32'b0000);
        bus_a.in_valid = 4'b1111;
        #1;
        check("rst.ready_busy", 32'(bus_a.in_ready), 32'b0000);
        bus_a.in_valid = '0;
        rst = 1'b0;
        step();
        check("idle.valid", 32'(bus_a.out_valid), 32'd0);

        // Explicit select
        bus_a.in_data   = {8'h40, 8'hA5, 8'h20, 8'h10};
        mode_a          = 1'b0;
        sel_a           = 2'd2;
        bus_a.in_valid  = 4'b0111;
        bus_a.out_ready = 1'b1;
        #1;
        check("sel.ready", 32'(bus_a.in_ready), 32'b0100);
        step();
        out_a("sel.out", 8'hA5, 2'd2);
        bus_a.in_valid = 4'b0011;
        #1;
        check("sel.novalid", 32'(bus_a.in_ready), 32'b0000);
        step();
        check("drain.valid", 32'(bus_a.out_valid), 32'd0);
        check("drain.data", 32'(bus_a.out_data), 32'hA5);

        // sel >= N never grants on the 3-channel instance
        mode_b         = 1'b0;
        sel_b          = 2'd3;
        bus_b.in_valid = 3'b111;
        #1;
        check("selN.ready", 32'(bus_b.in_ready), 32'b000);
        sel_b = 2'd1;
        #1;
        check("selB.ready", 32'(bus_b.in_ready), 32'b010);
        bus_b.in_valid = '0;

        // Explicit grant of ch3, then round-robin continues from ch0
        bus_a.in_data  = {8'h40, 8'h30, 8'h20, 8'h10};
        sel_a          = 2'd3;
        bus_a.in_valid = 4'b1000;
        step();
        out_a("sel3.out", 8'h40, 2'd3);
        mode_a         = 1'b1;
        bus_a.in_valid = 4'b1111;
        #1;
        check("rr.ready0", 32'(bus_a.in_ready), 32'b0001);
        step();
        out_a("rr.w0", 8'h10, 2'd0);
        step();
        out_a("rr.w1", 8'h20, 2'd1);
        step();
        out_a("rr.w2", 8'h30, 2'd2);
        step();
        out_a("rr.w3", 8'h40, 2'd3);
        step();
        out_a("rr.w4", 8'h10, 2'd0);

        // Backpressure
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp.ready", 32'(bus_a.in_ready), 32'b0000);
            step();
            out_a("bp.hold", 8'h10, 2'd0);
        end
        bus_a.out_ready = 1'b1;
        #1;
        check("bp.release", 32'(bus_a.in_ready), 32'b0010);
        step();
        out_a("bp.next", 8'h20, 2'd1);
        step();
        out_a("bp.after", 8'h30, 2'd2);

        // Sparse round-robin from rr_ptr=1
        bus_a.in_valid = 4'b0010;
        step();
        out_a("sp.ch1", 8'h20, 2'd1);
        bus_a.in_valid = 4'b1001;
        #1;
        check("sp.ready", 32'(bus_a.in_ready), 32'b1000);
        step();
        out_a("sp.ch3", 8'h40, 2'd3);
        step();
        out_a("sp.ch0", 8'h10, 2'd0);

        // Reset mid-stream while holding a word
        bus_a.in_valid = 4'b0100;
        step();
        out_a("mid.load", 8'h30, 2'd2);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 4'b0000;
        step();
        out_a("mid.hold", 8'h30, 2'd2);
        mode_a         = 1'b0;
        sel_a          = 2'd1;
        bus_a.in_valid = 4'b0010;
        #1;
        check("mid.ready", 32'(bus_a.in_ready), 32'b0000);
        step();
        out_a("mid.hold2", 8'h30, 2'd2);
        rst = 1'b1;
        #1;
        check("mid.rst_ready", 32'(bus_a.in_ready), 32'b0000);
        step();
        check("mid.rst_valid", 32'(bus_a.out_valid), 32'd0);
        check("mid.rst_data", 32'(bus_a.out_data), 32'h00);
        check("mid.rst_src", 32'(bus_a.out_src), 32'd0);
        rst             = 1'b0;
        mode_a          = 1'b1;
        bus_a.in_valid  = 4'b1111;
        bus_a.out_ready = 1'b1;
        #1;
        check("post.ready", 32'(bus_a.in_ready), 32'b0001);
        step();
        out_a("post.w0", 8'h10, 2'd0);
        bus_a.in_valid = '0;

        // Round-robin wrap on the 3-channel instance
        mode_b          = 1'b1;
        bus_b.in_valid  = 3'b111;
        bus_b.out_ready = 1'b1;
        step();
        out_b("n3.w0", 8'h10, 2'd0);
        step();
        out_b("n3.w1", 8'h20, 2'd1);
        step();
        out_b("n3.w2", 8'h30, 2'd2);
        step();
        out_b("n3.w3", 8'h10, 2'd0);
        step();
        out_b("n3.w4", 8'h20, 2'd1);
        bus_b.in_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N:1 streaming multiplexer with a registered output stage. It generalises the team's combinational 2/4/8-way 8-bit muxes to any width and channel count.
- Adds a valid/ready handshake on every input and on the output.
- Two select modes: explicit select (MODE_SEL) and round-robin arbitration (MODE_RR).
- Sits between multiple 8-bit producers (register file read ports, ALU, I/O) and a single consumer on the CPU data bus.

Parameters:
WIDTH, 8, data width of each channel in bits
N, 4, number of input channels (2..16, need not be a power of two)
SELW, $clog2(N), width of sel and out_src (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mode  input  1  0 = explicit select, 1 = round-robin
sel  input  SELW  channel index used when mode=0
in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept (combinational)
out_data  output  WIDTH  registered selected data
out_valid  output  1  registered output valid
out_ready  input  1  consumer accept
out_src  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset: one clock is fixed; reset is synchronous and active-high, sampled on the clk rising edge. While rst=1: out_valid=0, out_data=0, out_src=0, rr_ptr=N-1, so channel 0 has first round-robin priority.
- Reset mid-operation: any held output word is discarded with no acceptance. in_ready is all-zero while rst=1.
- space = !out_valid || out_ready. The output register can load this cycle, which gives full throughput under continuous out_ready.
- Grant, mode=0: grant = sel when sel < N and in_valid[sel]=1; otherwise there is no grant.
  - sel >= N never grants.
  - A valid word on another channel is ignored.
- Grant, mode=1: grant is the first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... and wrapping modulo N (not modulo 2^SELW). If no channel is valid, there is no grant.
- in_ready[i] = grant exists && i==grant && space. At most one bit is set, and the value is purely combinational from current inputs and state.
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge.
  - Next cycle: out_data=in_data[i], out_src=i, out_valid=1.
  - rr_ptr=i in either mode, so switching to mode=1 continues fairly from the last granted channel.
- Output drain: out_valid && out_ready with no input transfer gives out_valid=0 next cycle. out_data and out_src hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge and out_valid stays 1.
- Hold: out_valid && !out_ready keeps out_data and out_src stable and in_ready all-zero, regardless of input or mode changes.
- Latency: exactly 1 cycle from input transfer to out_valid. Throughput is 1 word/cycle.
- Mode and sel are sampled combinationally each cycle. A change affects the grant in the same cycle and needs no pipeline flush.
- A producer may drop in_valid before it is accepted. Nothing is latched from an unaccepted channel.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all in_valid=0 -> out_valid=0, out_data=0x00, out_src=0, in_ready=0000; after release, still out_valid=0.
2. Explicit select: mode=0, sel=2, in_data ch2=0xA5, in_valid=0111, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_src=2, out_valid=1. With sel=2 and in_valid[2]=0 -> in_ready=0000.
3. Round-robin fairness: mode=1, in_valid=1111 held, data ch0..3=0x10,0x20,0x30,0x40, out_ready=1 -> out_data sequence 0x10,0x20,0x30,0x40,0x10 on consecutive cycles. Repeat with N=3 to confirm the wrap 0,1,2,0 and that index 3 is never produced.
4. Backpressure: mode=1, out_ready=0 after the first word 0x10 -> out_data stays 0x10 and in_ready=0000 for 5 cycles. Raise out_ready -> 0x20 appears the following cycle with no word lost or duplicated.
5. Sparse round-robin: mode=1, rr_ptr=1 (after ch1 granted), in_valid=1001 -> ch3 is granted first, then ch0.
6. Reset mid-stream: out_valid=1 holding 0x30 with out_ready=0, assert rst -> next cycle out_valid=0, out_data=0x00. The first post-reset round-robin grant with in_valid=1111 goes to ch0.
